lsu_mem_ctrl: RTL and testbench

Load/store controller that drives the single-port-write, asynchronous-read data RAM on behalf of the RISC-V core. It accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake and converts them into word accesses on the RAM's write and read ports. Loads are extracted and extended; sub-word stores are merged by read-modify-write. It sits between the core's memory stage and the data RAM and is the only master of that RAM.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_mem_ctrl.sv | 115 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, controller state type and data width for the load/store unit.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extract/extend a load from a RAM word, or merge store data into it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] mem_word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lane_lsb;

  assign lane_lsb = {addr_lo_i, 3'b000};
  assign byte_sel = mem_word_i[lane_lsb +: 8];
  assign half_sel = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data_o = mem_word_i;
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = '0;
    endcase
  end

  // Untouched lanes keep the current RAM contents (read-modify-write).
  always_comb begin
    store_data_o = mem_word_i;
    case (funct3_i)
      F3_B: store_data_o[lane_lsb +: 8] = wdata_i[7:0];
      F3_H: begin
        if (addr_lo_i[1]) store_data_o[31:16] = wdata_i[15:0];
        else              store_data_o[15:0]  = wdata_i[15:0];
      end
      F3_W:    store_data_o = wdata_i;
      default: store_data_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller mastering an async-read, single-write-port data RAM.
// Optional LSU_RANGE_CHECK_EN: upper address bits beyond the RAM flag an error instead of aliasing.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [31:0]           REQ_ADDR,
  input  logic [DATA_W-1:0]     REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_W-1:0]     RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR_W,
  output logic                  MEM_ENABLE_W,
  output logic [DATA_W-1:0]     MEM_Q_W,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR_R,
  input  logic [DATA_W-1:0]     MEM_Q_R
);

  lsu_state_t            state_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  err_d;
  logic                  wr_en;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     store_data;

  always_comb begin
    err_d = 1'b0;
    case (REQ_FUNCT3)
      F3_B:    err_d = 1'b0;
      F3_H:    err_d = REQ_ADDR[0];
      F3_W:    err_d = |REQ_ADDR[1:0];
      F3_BU:   err_d = REQ_WE;
      F3_HU:   err_d = REQ_WE | REQ_ADDR[0];
      default: err_d = 1'b1;
    endcase
`ifdef LSU_RANGE_CHECK_EN
    if (|REQ_ADDR[31:ADDR_WIDTH+2]) err_d = 1'b1;
`endif
  end

`ifndef LSU_RANGE_CHECK_EN
  // Upper bits deliberately dropped: accesses alias modulo the RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^REQ_ADDR[31:ADDR_WIDTH+2];
`endif

  lsu_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .mem_word_i   (MEM_Q_R),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // Gated by RESET so a reset landing in ACCESS suppresses the commit.
  assign wr_en        = (state_q == ACCESS) && we_q && !RESET;
  assign MEM_ENABLE_W = wr_en;
  assign MEM_Q_W      = wr_en ? store_data : '0;
  assign MEM_ADDR_W   = addr_q[ADDR_WIDTH+1:2];
  assign MEM_ADDR_R   = addr_q[ADDR_WIDTH+1:2];

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            we_q    <= REQ_WE;
            f3_q    <= REQ_FUNCT3;
            addr_q  <= REQ_ADDR[ADDR_WIDTH+1:0];
            wdata_q <= REQ_WDATA;
            rdata_q <= '0;
            err_q   <= err_d;
            state_q <= err_d ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          rdata_q <= we_q ? '0 : load_data;
          state_q <= RESP;
        end
        RESP: begin
          if (RSP_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural async-read RAM; honours LSU_RANGE_CHECK_EN.
module tb_lsu_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [9:0]  MEM_ADDR_W, MEM_ADDR_R;
  logic        MEM_ENABLE_W;
  logic [31:0] MEM_Q_W, MEM_Q_R;

  logic [31:0] ram [0:1023];
  int          wr_cnt = 0;
  logic [9:0]  last_wa = '0;
  int          checks = 0;
  int          failures = 0;
  int          exp_wr = 0;
  logic [31:0] rd;
  logic        er;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl #(.ADDR_WIDTH(10)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_ADDR_W(MEM_ADDR_W), .MEM_ENABLE_W(MEM_ENABLE_W), .MEM_Q_W(MEM_Q_W),
    .MEM_ADDR_R(MEM_ADDR_R), .MEM_Q_R(MEM_Q_R)
  );

  assign MEM_Q_R = ram[MEM_ADDR_R];

  always @(posedge CLK) begin
    if (MEM_ENABLE_W) begin
      ram[MEM_ADDR_W] <= MEM_Q_W;
      last_wa         <= MEM_ADDR_W;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; RSP_READY is raised only once the response is observed.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic exp_err,
                      output logic [31:0] rdata, output logic err);
    chk({tag, "_rdy"}, {31'd0, REQ_READY}, 32'd1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    if (!exp_err) begin
      chk({tag, "_acc"}, {30'd0, RSP_VALID, REQ_READY}, 32'd0);
      @(posedge CLK); #1;
    end
    chk({tag, "_vld"}, {31'd0, RSP_VALID}, 32'd1);
    rdata = RSP_RDATA;
    err   = RSP_ERR;
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = '0;
    REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_flags", {29'd0, RSP_VALID, RSP_ERR, MEM_ENABLE_W}, 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_addr", {12'd0, MEM_ADDR_W, MEM_ADDR_R}, 32'd0);
    chk("rst_qw", MEM_Q_W, 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    xact("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    exp_wr++;
    chk("sw10_cnt", wr_cnt, exp_wr);
    chk("sw10_wa", {22'd0, last_wa}, 32'd4);
    chk("sw10_rd", rd, 32'd0);
    xact("lw10", 0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw10_rd", rd, 32'hDEADBEEF);

    xact("sb13", 1, 3'b000, 32'h13, 32'hAAAAAA55, 0, rd, er);
    exp_wr++;
    xact("lw10b", 0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw10b_rd", rd, 32'h55ADBEEF);
    xact("lb13", 0, 3'b000, 32'h13, 32'h0, 0, rd, er);
    chk("lb13_rd", rd, 32'h00000055);
    xact("lb12", 0, 3'b000, 32'h12, 32'h0, 0, rd, er);
    chk("lb12_rd", rd, 32'hFFFFFFAD);
    xact("lbu12", 0, 3'b100, 32'h12, 32'h0, 0, rd, er);
    chk("lbu12_rd", rd, 32'h000000AD);

    xact("sh12", 1, 3'b001, 32'h12, 32'h12348001, 0, rd, er);
    exp_wr++;
    xact("lh12", 0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    chk("lh12_rd", rd, 32'hFFFF8001);
    xact("lhu12", 0, 3'b101, 32'h12, 32'h0, 0, rd, er);
    chk("lhu12_rd", rd, 32'h00008001);
    xact("lw10c", 0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw10c_rd", rd, 32'h8001BEEF);
    xact("lh10", 0, 3'b001, 32'h10, 32'h0, 0, rd, er);
    chk("lh10_rd", rd, 32'hFFFFBEEF);
    xact("lbu11", 0, 3'b100, 32'h11, 32'h0, 0, rd, er);
    chk("lbu11_rd", rd, 32'h000000BE);
    chk("wcnt_a", wr_cnt, exp_wr);

    xact("lw11", 0, 3'b010, 32'h11, 32'h0, 1, rd, er);
    chk("lw11_rd", rd, 32'd0);
    xact("sh13", 1, 3'b001, 32'h13, 32'hFFFF, 1, rd, er);
    xact("sw12", 1, 3'b010, 32'h12, 32'h0, 1, rd, er);
    xact("ld_f3_011", 0, 3'b011, 32'h10, 32'h0, 1, rd, er);
    xact("st_f3_100", 1, 3'b100, 32'h10, 32'h0, 1, rd, er);
    chk("err_nowr", wr_cnt, exp_wr);
    chk("err_ram", ram[4], 32'h8001BEEF);

`ifdef LSU_RANGE_CHECK_EN
    xact("sw1000", 1, 3'b010, 32'h1000, 32'h11223344, 1, rd, er);
    chk("sw1000_cnt", wr_cnt, exp_wr);
    chk("sw1000_ram", ram[0], 32'd0);
`else
    xact("sw1000", 1, 3'b010, 32'h1000, 32'h11223344, 0, rd, er);
    exp_wr++;
    chk("sw1000_cnt", wr_cnt, exp_wr);
    chk("sw1000_ram", ram[0], 32'h11223344);
`endif

    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h10;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h14; REQ_WDATA = 32'h5A5A5A5A;
    for (int c = 0; c < 5; c++) begin
      chk("hold_vld", {31'd0, RSP_VALID}, 32'd1);
      chk("hold_rd", RSP_RDATA, 32'h8001BEEF);
      chk("hold_rdy", {31'd0, REQ_READY}, 32'd0);
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
    chk("hold_nowr", wr_cnt, exp_wr);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk("hold_idle", {31'd0, REQ_READY}, 32'd1);

    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h20; REQ_WDATA = 32'hCAFEF00D;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("rsta_we_pre", {31'd0, MEM_ENABLE_W}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("rsta_we_rst", {31'd0, MEM_ENABLE_W}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rsta_idle", {29'd0, REQ_READY, RSP_VALID, RSP_ERR}, 32'd4);
    chk("rsta_rdata", RSP_RDATA, 32'd0);
    chk("rsta_addr", {22'd0, MEM_ADDR_W}, 32'd0);
    chk("rsta_nowr", wr_cnt, exp_wr);
    chk("rsta_ram", ram[8], 32'd0);
    xact("lw20", 0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    chk("lw20_rd", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
